// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types and constants for the load/store controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
   localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;

   // Halfwords need an even address, words a 4-byte aligned one.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      logic mis;
      mis = 1'b0;
      case (funct3)
         F3_H, F3_HU: mis = offset[0];
         F3_W:        mis = (offset != 2'd0);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_store_align.sv
// ============================================================================
// Module   : lsu_store_align
// Brief    : Combinational store byte-lane alignment of data and byte mask.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_store_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] sdata,
   output logic [31:0] wdata,
   output logic [7:0]  wmask
);

   logic [3:0] w_mask4;

   always_comb begin
      w_mask4 = 4'h0;
      case (funct3)
         F3_B:    w_mask4 = 4'h1 << offset;
         F3_H:    w_mask4 = 4'h3 << offset;
         F3_W:    w_mask4 = 4'hF;
         default: w_mask4 = 4'h0;
      endcase
   end

   // Only four byte lanes exist; the upper mask nibble stays zero.
   assign wmask = {4'h0, w_mask4};
   assign wdata = sdata << {offset, 3'b000};

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Multicycle load/store controller in front of the MEM stage.
//            Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 1
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_base,
   input  logic [31:0] in_imm,
   input  logic [31:0] in_sdata,
   input  logic [4:0]  in_rd,
   output logic        mem_access,
   output logic        read,
   output logic        wen,
   output logic [2:0]  readop,
   output logic [7:0]  wmask,
   output logic [31:0] raddr,
   output logic [31:0] waddr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic [4:0]  out_rd,
   output logic        out_rf_wen,
   output logic        out_exc,
   output logic [3:0]  out_cause
);

   // Out-of-range latencies are clamped into the 1..15 counter range.
   localparam logic [3:0] c_lat = (MEM_LATENCY == 0)  ? 4'd1  :
                                  (MEM_LATENCY > 15)  ? 4'd15 : 4'(MEM_LATENCY);

   lsu_state_t  r_state;
   lsu_state_t  w_next;
   logic        r_is_load;
   logic        r_is_store;
   logic [3:0]  r_cnt;
   logic [31:0] r_addr;

   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [7:0]  w_wmask;
   logic        w_is_mem;
   logic        w_mis;

   assign w_addr   = in_base + in_imm;
   assign w_is_mem = in_is_load | in_is_store;

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_mis = w_is_mem & is_misaligned(in_funct3, w_addr[1:0]);
`else
   assign w_mis = 1'b0;
`endif

   lsu_store_align u_align (
      .funct3 (in_funct3),
      .offset (w_addr[1:0]),
      .sdata  (in_sdata),
      .wdata  (w_wdata),
      .wmask  (w_wmask)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_next = (w_is_mem && !w_mis) ? REQ : RESP;
            end
         end
         REQ:  w_next = WAIT;
         WAIT: begin
            if (r_cnt <= 4'd1) begin
               w_next = RESP;
            end
         end
         RESP: begin
            if (out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Strobes decode straight from state so reset drops them without a clock.
   assign in_ready   = (r_state == IDLE);
   assign out_valid  = (r_state == RESP);
   assign mem_access = (r_state == REQ);
   assign read       = mem_access & r_is_load;
   assign wen        = mem_access & r_is_store;
   assign raddr      = r_addr;
   assign waddr      = r_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_load  <= 1'b0;
         r_is_store <= 1'b0;
         r_cnt      <= 4'd0;
         r_addr     <= 32'd0;
         readop     <= 3'd0;
         wmask      <= 8'd0;
         wdata      <= 32'd0;
         out_rdata  <= 32'd0;
         out_rd     <= 5'd0;
         out_rf_wen <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_is_load  <= in_is_load & ~w_mis;
                  r_is_store <= in_is_store & ~w_mis;
                  r_addr     <= w_addr;
                  readop     <= in_funct3;
                  out_rd     <= in_rd;
                  out_rf_wen <= in_is_load & (in_rd != 5'd0) & ~w_mis;
                  out_rdata  <= w_mis ? w_addr : 32'd0;
                  if (in_is_store && !w_mis) begin
                     wmask <= w_wmask;
                     wdata <= w_wdata;
                  end else begin
                     wmask <= 8'd0;
                     wdata <= 32'd0;
                  end
               end
            end
            REQ: r_cnt <= c_lat;
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt <= 4'd1 && r_is_load) begin
                  out_rdata <= rdata;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic       r_exc;
   logic [3:0] r_cause;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exc   <= 1'b0;
         r_cause <= 4'd0;
      end else if (r_state == IDLE && in_valid) begin
         r_exc   <= w_mis;
         r_cause <= !w_mis ? 4'd0 : (in_is_store ? CAUSE_SMISALIGN : CAUSE_LMISALIGN);
      end
   end

   assign out_exc   = r_exc;
   assign out_cause = r_cause;
`else
   assign out_exc   = 1'b0;
   assign out_cause = 4'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Scoreboard bench for lsu_ctrl (honours LSU_MISALIGN_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

   localparam int LAT = 1;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_is_load = 1'b0;
   logic        in_is_store = 1'b0;
   logic [2:0]  in_funct3 = 3'd0;
   logic [31:0] in_base = 32'd0;
   logic [31:0] in_imm = 32'd0;
   logic [31:0] in_sdata = 32'd0;
   logic [4:0]  in_rd = 5'd0;
   logic        mem_access;
   logic        read;
   logic        wen;
   logic [2:0]  readop;
   logic [7:0]  wmask;
   logic [31:0] raddr;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_rdata;
   logic [4:0]  out_rd;
   logic        out_rf_wen;
   logic        out_exc;
   logic [3:0]  out_cause;

   always #5 clk = ~clk;

   lsu_ctrl #(.MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
      .in_base(in_base), .in_imm(in_imm), .in_sdata(in_sdata), .in_rd(in_rd),
      .mem_access(mem_access), .read(read), .wen(wen), .readop(readop),
      .wmask(wmask), .raddr(raddr), .waddr(waddr), .wdata(wdata), .rdata(rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_rd(out_rd), .out_rf_wen(out_rf_wen), .out_exc(out_exc), .out_cause(out_cause)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // MEM model: result is valid only exactly LAT cycles after the request.
   logic [31:0] mem_word = 32'h1122_3344;
   int          req_age;

   function automatic logic [31:0] mem_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] o);
      logic [31:0] s;
      s = w >> (8 * o);
      case (f3)
         3'd0:    return {{24{s[7]}}, s[7:0]};
         3'd1:    return {{16{s[15]}}, s[15:0]};
         3'd4:    return {24'd0, s[7:0]};
         3'd5:    return {16'd0, s[15:0]};
         default: return s;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)               req_age <= 0;
      else if (mem_access)      req_age <= 1;
      else if (req_age != 0)    req_age <= req_age + 1;
   end

   always_comb rdata = (req_age == LAT) ? mem_ext(mem_word, readop, raddr[1:0]) : 32'hBAD0_BAD0;

   typedef struct {
      logic [31:0] addr;
      logic        rd_op;
      logic        wr_op;
      logic [2:0]  op;
      logic [7:0]  mask;
      logic [31:0] data;
   } req_t;

   typedef struct {
      logic [31:0] rdata;
      logic [4:0]  rd;
      logic        rf_wen;
      logic        exc;
      logic [3:0]  cause;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   req_t mon_req;
   rsp_t mon_rsp;
   int   mem_cycles = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_access) begin
            mem_cycles++;
            if (req_q.size() == 0) begin
               chk_eq("unexpected_req", 32'd1, 32'd0);
            end else begin
               mon_req = req_q.pop_front();
               chk_eq("raddr", raddr, mon_req.addr);
               chk_eq("waddr", waddr, mon_req.addr);
               chk_eq("read", read, mon_req.rd_op);
               chk_eq("wen", wen, mon_req.wr_op);
               chk_eq("readop", readop, mon_req.op);
               chk_eq("wmask", wmask, mon_req.mask);
               chk_eq("wdata", wdata, mon_req.data);
            end
         end
         if (out_valid && out_ready) begin
            if (rsp_q.size() == 0) begin
               chk_eq("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               mon_rsp = rsp_q.pop_front();
               chk_eq("out_rdata", out_rdata, mon_rsp.rdata);
               chk_eq("out_rd", out_rd, mon_rsp.rd);
               chk_eq("out_rf_wen", out_rf_wen, mon_rsp.rf_wen);
               chk_eq("out_exc", out_exc, mon_rsp.exc);
               chk_eq("out_cause", out_cause, mon_rsp.cause);
            end
         end
      end
   end

   // Computes expectations, pushes them, and presents the op for one accept edge.
   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] imm, input logic [31:0] sd,
                        input logic [4:0] rd, input logic [31:0] memw,
                        output int exp_lat, output logic exp_req, output logic [31:0] exp_rdata);
      logic [31:0] a;
      logic [1:0]  o;
      logic        mis;
      logic [3:0]  m4;
      req_t        rq;
      rsp_t        rs;
      a   = base + imm;
      o   = a[1:0];
      mis = TRAP && (ld || st) &&
            (((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && o != 2'd0));
      m4  = (f3 == 3'd0) ? (4'h1 << o) : (f3 == 3'd1) ? (4'h3 << o) : (f3 == 3'd2) ? 4'hF : 4'h0;
      exp_req = (ld || st) && !mis;
      exp_lat = exp_req ? 2 + LAT : 1;
      rq.addr  = a;
      rq.rd_op = ld;
      rq.wr_op = st;
      rq.op    = f3;
      rq.mask  = st ? {4'h0, m4} : 8'h00;
      rq.data  = st ? (sd << (8 * o)) : 32'd0;
      rs.rd     = rd;
      rs.rf_wen = ld && !mis && (rd != 5'd0);
      rs.exc    = mis;
      rs.cause  = !mis ? 4'd0 : (st ? 4'd6 : 4'd4);
      rs.rdata  = mis ? a : (ld ? mem_ext(memw, f3, o) : 32'd0);
      exp_rdata = rs.rdata;
      if (exp_req) req_q.push_back(rq);
      rsp_q.push_back(rs);
      mem_word    = memw;
      in_is_load  = ld;
      in_is_store = st;
      in_funct3   = f3;
      in_base     = base;
      in_imm      = imm;
      in_sdata    = sd;
      in_rd       = rd;
      in_valid    = 1'b1;
      chk_eq("in_ready_idle", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_base   = $urandom();
      in_sdata  = $urandom();
      in_funct3 = 3'($urandom_range(0, 7));
   endtask

   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] imm, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [31:0] memw, input int hold);
      int          lat;
      int          lat_e;
      int          m0;
      logic        req_e;
      logic [31:0] rd_e;
      m0 = mem_cycles;
      issue(ld, st, f3, base, imm, sd, rd, memw, lat_e, req_e, rd_e);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk_eq("latency", lat, lat_e);
      for (int i = 0; i < hold; i++) begin
         chk_eq("hold_valid", out_valid, 1'b1);
         chk_eq("hold_in_ready", in_ready, 1'b0);
         chk_eq("hold_rdata", out_rdata, rd_e);
         in_valid   = 1'b1;
         in_is_load = 1'b1;
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk_eq("ret_idle", in_ready, 1'b1);
      chk_eq("ret_valid", out_valid, 1'b0);
      chk_eq("req_count", mem_cycles - m0, req_e ? 32'd1 : 32'd0);
   endtask

   int          lat_x;
   logic        req_x;
   logic [31:0] rd_x;

   initial begin
      #12;
      chk_eq("rst_in_ready", in_ready, 1'b1);
      chk_eq("rst_out_valid", out_valid, 1'b0);
      chk_eq("rst_mem_access", mem_access, 1'b0);
      chk_eq("rst_out_rdata", out_rdata, 32'd0);
      chk_eq("rst_wmask", wmask, 8'd0);
      chk_eq("rst_out_rf_wen", out_rf_wen, 1'b0);
      chk_eq("rst_out_exc", out_exc, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'd4, 32'hDEAD_BEEF, 5'd7, 32'h0, 0);
      run_op(1'b0, 1'b1, 3'd0, 32'h8000_0000, 32'd3, 32'h0000_00A5, 5'd1, 32'h0, 0);
      run_op(1'b1, 1'b0, 3'd4, 32'h8000_0000, 32'd1, 32'h0, 5'd5, 32'h1122_3344, 5);
      run_op(1'b1, 1'b0, 3'd0, 32'h8000_0004, 32'hFFFF_FFFF, 32'h0, 5'd9, 32'h8A22_3344, 0);
      run_op(1'b1, 1'b0, 3'd1, 32'h8000_0000, 32'd2, 32'h0, 5'd10, 32'h8001_1234, 0);
      run_op(1'b1, 1'b0, 3'd5, 32'h8000_0000, 32'd2, 32'h0, 5'd11, 32'h8001_1234, 2);
      run_op(1'b1, 1'b0, 3'd2, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0, 5'd0, 32'hCAFE_F00D, 0);
      run_op(1'b0, 1'b1, 3'd1, 32'h8000_0000, 32'd2, 32'h1234_BEEF, 5'd3, 32'h0, 0);
      run_op(1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'd0, 32'h0, 5'd4, 32'h0, 1);
      run_op(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'd2, 32'h0, 5'd6, 32'h5566_7788, 0);
      run_op(1'b0, 1'b1, 3'd1, 32'h8000_0000, 32'd1, 32'hABCD_0123, 5'd2, 32'h0, 0);

      // Reset in the WAIT cycle of a load abandons it.
      issue(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'd0, 32'h0, 5'd8, 32'h0BAD_CAFE, lat_x, req_x, rd_x);
      @(posedge clk); #1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("midrst_in_ready", in_ready, 1'b1);
      chk_eq("midrst_out_valid", out_valid, 1'b0);
      chk_eq("midrst_mem_access", mem_access, 1'b0);
      req_q.delete();
      rsp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(1'b1, 1'b0, 3'd2, 32'h8000_0000, 32'd8, 32'h0, 5'd12, 32'h1357_9BDF, 0);

      chk_eq("queues_drained", req_q.size() + rsp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
